// File: rtl/ahb_output_arbiter_param.sv
// Output-stage arbiter for one AHB matrix slave port: round-robin or fixed priority, burst hold,
// early-INCR anti-lockout and optional hold timeout. Grant changes one HREADYM-qualified edge after request.
module ahb_output_arbiter_param #(
  parameter int NUM_PORTS        = 4,
  parameter int PORT_W           = 2,
  parameter int ARB_MODE         = 0,
  parameter int INCR_HOLD_BEATS  = 4,
  parameter int EARLY_INCR_LIMIT = 1,
  parameter int MAX_HOLD         = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic [NUM_PORTS-1:0] grant_onehot,
  output logic                 burst_hold
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [1:0] EARLY_LIM = 2'(EARLY_INCR_LIMIT);
  localparam logic [3:0] INCR_REM  = 4'(INCR_HOLD_BEATS - 2);

  logic [3:0]        remain_q, remain_n;
  logic              hold_q, hold_n, eff_hold, timeout;
  logic [1:0]        early_q, early_inc;
  logic [PORT_W-1:0] grant_q, grant_n;
  logic              no_port_q, no_port_n;
  logic              found;
  int                idx;

  // A NONSEQ while still holding means the previous INCR ended early; that burst counts now.
  always_comb begin
    early_inc = early_q;
    if (hold_q && HTRANSM == TR_NONSEQ && early_q != EARLY_LIM)
      early_inc = early_q + 2'd1;
  end

  always_comb begin
    remain_n = remain_q;
    hold_n   = hold_q;
    if (!HSELM) begin
      remain_n = '0;
      hold_n   = 1'b0;
    end else begin
      case (HTRANSM)
        TR_NONSEQ: begin
          case (HBURSTM)
            3'b110, 3'b111: begin remain_n = 4'd14; hold_n = 1'b1; end
            3'b100, 3'b101: begin remain_n = 4'd6;  hold_n = 1'b1; end
            3'b010, 3'b011: begin remain_n = 4'd2;  hold_n = 1'b1; end
            3'b001: begin
              if (early_inc == EARLY_LIM) begin
                remain_n = '0;
                hold_n   = 1'b0;
              end else begin
                remain_n = INCR_REM;
                hold_n   = 1'b1;
              end
            end
            default: begin remain_n = '0; hold_n = 1'b0; end
          endcase
        end
        TR_SEQ: begin
          if (remain_q == 4'd0) hold_n = 1'b0;
          else                  remain_n = remain_q - 4'd1;
        end
        TR_BUSY: ;
        default: begin remain_n = '0; hold_n = 1'b0; end
      endcase
    end
  end

  generate
    if (MAX_HOLD > 0) begin : g_tmr
      logic [7:0] tmr_q;
      assign timeout = hold_q && (tmr_q == 8'(MAX_HOLD - 1));
      always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)     tmr_q <= '0;
        else if (HREADYM) tmr_q <= (hold_q && !timeout) ? tmr_q + 8'd1 : '0;
      end
    end else begin : g_no_tmr
      assign timeout = 1'b0;
    end
  endgenerate

  assign eff_hold = hold_n && !timeout;

  always_comb begin
    grant_n   = grant_q;
    no_port_n = no_port_q;
    found     = 1'b0;
    idx       = 0;
    if (!(HMASTLOCKM || eff_hold)) begin
      if (no_port_q || ARB_MODE != 0) begin
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
          if (req_port[i]) begin
            grant_n = PORT_W'(i);
            found   = 1'b1;
          end
        end
      end else begin
        // Descending scan so the last hit is the nearest port after the current one.
        for (int i = NUM_PORTS - 1; i >= 1; i--) begin
          idx = (int'(grant_q) + i) % NUM_PORTS;
          if (req_port[idx]) begin
            grant_n = PORT_W'(idx);
            found   = 1'b1;
          end
        end
      end
      if (found)       no_port_n = 1'b0;
      else if (!HSELM) no_port_n = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      remain_q  <= '0;
      hold_q    <= 1'b0;
      early_q   <= '0;
      grant_q   <= '0;
      no_port_q <= 1'b1;
    end else if (HREADYM) begin
      remain_q  <= timeout ? 4'd0 : remain_n;
      hold_q    <= eff_hold;
      early_q   <= eff_hold ? early_inc : 2'd0;
      grant_q   <= grant_n;
      no_port_q <= no_port_n;
    end
  end

  assign addr_in_port = grant_q;
  assign no_port      = no_port_q;
  assign burst_hold   = hold_q;
  assign grant_onehot = no_port_q ? '0 : (NUM_PORTS'(1) << grant_q);

endmodule
